// File: rtl/ei_axi4_wr_responder.sv
// AXI4 slave write responder: takes one AW burst at a time, consumes its W beats,
// emits one registered memory write per beat and returns a single B response.
module ei_axi4_wr_responder #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic [ID_WIDTH-1:0]     awid,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic [2:0]              awsize,
  input  logic [1:0]              awburst,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [ID_WIDTH-1:0]     bid,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb
);
  localparam int STRB_W = DATA_WIDTH / 8;
  localparam logic [2:0] SIZE_MAX = 3'($clog2(STRB_W));
  localparam logic [ADDR_WIDTH-1:0] A_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;
  state_t r_state, w_state_nxt;

  // captured burst context
  logic [ID_WIDTH-1:0]   r_id;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [7:0]            r_len, r_cnt;
  logic [2:0]            r_size;
  logic [1:0]            r_burst;
  logic                  r_err, r_sup;

  // registered outputs
  logic                  r_awready, r_wready, r_bvalid, r_mem_we;
  logic [ID_WIDTH-1:0]   r_bid;
  logic [1:0]            r_bresp;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_wdata;
  logic [STRB_W-1:0]     r_mem_wstrb;

  logic w_aw_hs, w_w_hs, w_b_hs, w_last, w_fin, w_wlast_err;
  logic w_aw_size_err, w_aw_wrap_err;
  logic [ADDR_WIDTH-1:0] w_aw_mask, w_inc, w_bound, w_addr_incr, w_addr_wrap, w_addr_nxt;

  assign w_aw_hs     = awvalid & r_awready;
  assign w_w_hs      = wvalid & r_wready;
  assign w_b_hs      = r_bvalid & bready;
  assign w_last      = (r_cnt == r_len);
  assign w_fin       = w_w_hs & w_last;
  assign w_wlast_err = wlast ^ w_last;

  // Conditions that make the whole burst unwritable are judged once, at AW time.
  assign w_aw_mask     = (A_ONE << awsize) - A_ONE;
  assign w_aw_size_err = (awsize > SIZE_MAX);
  assign w_aw_wrap_err = (awburst == 2'b10) &&
                         (!(awlen == 8'd1 || awlen == 8'd3 || awlen == 8'd7 || awlen == 8'd15) ||
                          ((awaddr & w_aw_mask) != '0));

  // Beat address arithmetic; the wrap bound (len+1)*inc is a shift because inc is a power of two.
  assign w_inc       = A_ONE << r_size;
  assign w_bound     = (ADDR_WIDTH'(r_len) + A_ONE) << r_size;
  assign w_addr_incr = (r_addr & ~(w_inc - A_ONE)) + w_inc;
  assign w_addr_wrap = (r_addr & ~(w_bound - A_ONE)) | ((r_addr + w_inc) & (w_bound - A_ONE));

  // Next beat address; reserved burst type behaves as INCR.
  always_comb begin
    w_addr_nxt = w_addr_incr;
    case (r_burst)
      2'b00:   w_addr_nxt = r_addr;
      2'b10:   w_addr_nxt = w_addr_wrap;
      default: w_addr_nxt = w_addr_incr;
    endcase
  end

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic: final beat is decided by the beat count, not by wlast.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_aw_hs) w_state_nxt = S_DATA;
      S_DATA:  if (w_fin)   w_state_nxt = S_RESP;
      S_RESP:  if (w_b_hs)  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Burst context capture and per-beat address/count/error tracking.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_id <= '0; r_addr <= '0; r_len <= '0; r_size <= '0; r_burst <= '0;
      r_cnt <= '0; r_err <= 1'b0; r_sup <= 1'b0;
    end else if (w_aw_hs) begin
      r_id    <= awid;
      r_addr  <= awaddr;
      r_len   <= awlen;
      r_size  <= awsize;
      r_burst <= awburst;
      r_cnt   <= '0;
      r_sup   <= w_aw_size_err | w_aw_wrap_err;
      r_err   <= w_aw_size_err | w_aw_wrap_err | (awburst == 2'b11);
    end else if (w_w_hs) begin
      r_addr <= w_addr_nxt;
      r_cnt  <= r_cnt + 8'd1;
      r_err  <= r_err | w_wlast_err;
    end
  end

  // Handshake outputs follow the next state so they are registered yet never lag the FSM.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_awready <= 1'b0; r_wready <= 1'b0; r_bvalid <= 1'b0;
      r_bid <= '0; r_bresp <= '0;
    end else begin
      r_awready <= (w_state_nxt == S_IDLE);
      r_wready  <= (w_state_nxt == S_DATA);
      r_bvalid  <= (w_state_nxt == S_RESP);
      if (w_fin) begin
        r_bid   <= r_id;
        r_bresp <= (r_err | w_wlast_err) ? 2'b10 : 2'b00;
      end
    end
  end

  // One memory write per accepted beat, unless the burst was judged unwritable.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      r_mem_we <= 1'b0; r_mem_addr <= '0; r_mem_wdata <= '0; r_mem_wstrb <= '0;
    end else begin
      r_mem_we <= w_w_hs & ~r_sup;
      if (w_w_hs) begin
        r_mem_addr  <= r_addr;
        r_mem_wdata <= wdata;
        r_mem_wstrb <= wstrb;
      end
    end
  end

  assign awready   = r_awready;
  assign wready    = r_wready;
  assign bvalid    = r_bvalid;
  assign bid       = r_bid;
  assign bresp     = r_bresp;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
endmodule

// File: tb/tb_ei_axi4_wr_responder.sv
// Directed bench for ei_axi4_wr_responder at default parameters (16-bit addr, 32-bit data).
module tb_ei_axi4_wr_responder;
  logic        aclk = 1'b0, areset;
  logic [3:0]  awid;
  logic [15:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;

  int checks = 0, failures = 0;
  logic [15:0] qa[$];
  logic [3:0]  qs[$];
  logic [31:0] qd[$];

  ei_axi4_wr_responder dut (
    .aclk(aclk), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb)
  );

  always #5 aclk = ~aclk;

  // record every memory write pulse
  always @(negedge aclk) if (mem_we === 1'b1) begin
    qa.push_back(mem_addr); qs.push_back(mem_wstrb); qd.push_back(mem_wdata);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic aw(input logic [3:0] id, input logic [15:0] a, input logic [7:0] l,
                    input logic [2:0] s, input logic [1:0] b);
    int t = 0;
    awid = id; awaddr = a; awlen = l; awsize = s; awburst = b; awvalid = 1'b1;
    while (awready !== 1'b1 && t < 50) begin @(negedge aclk); t++; end
    chk("aw_wait", 32'(t < 50), 1);
    @(negedge aclk);
    awvalid = 1'b0;
  endtask

  task automatic wbeat(input logic [31:0] d, input logic [3:0] s, input logic l);
    int t = 0;
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1;
    while (wready !== 1'b1 && t < 50) begin @(negedge aclk); t++; end
    chk("w_wait", 32'(t < 50), 1);
    @(negedge aclk);
    wvalid = 1'b0;
  endtask

  task automatic bwait(input string tag, input logic [3:0] id, input logic [1:0] r);
    int t = 0;
    while (bvalid !== 1'b1 && t < 50) begin @(negedge aclk); t++; end
    chk({tag, "_bvalid"}, 32'(bvalid), 1);
    chk({tag, "_bid"}, 32'(bid), 32'(id));
    chk({tag, "_bresp"}, 32'(bresp), 32'(r));
    bready = 1'b1;
    @(negedge aclk);
    bready = 1'b0;
    chk({tag, "_b_drop"}, 32'(bvalid), 0);
    chk({tag, "_awready_back"}, 32'(awready), 1);
  endtask

  task automatic clrq();
    qa.delete(); qs.delete(); qd.delete();
  endtask

  initial begin
    areset = 1'b1; awvalid = 0; wvalid = 0; bready = 0;
    awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0;
    wdata = 0; wstrb = 0; wlast = 0;
    repeat (3) @(negedge aclk);
    chk("rst_awready", 32'(awready), 0);
    chk("rst_wready", 32'(wready), 0);
    chk("rst_bvalid", 32'(bvalid), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_bid", 32'(bid), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    areset = 1'b0;
    @(negedge aclk);
    chk("post_rst_awready", 32'(awready), 1);

    // INCR 0x100 len=3 size=2 id=5, back-to-back beats
    clrq();
    aw(4'd5, 16'h0100, 8'd3, 3'd2, 2'b01);
    chk("incr_awready_low", 32'(awready), 0);
    chk("incr_wready", 32'(wready), 1);
    for (int i = 0; i < 4; i++) wbeat(32'hA0 + i, 4'hF, i == 3);
    chk("incr_b_latency", 32'(bvalid), 1);
    bwait("incr", 4'd5, 2'b00);
    chk("incr_nwr", qa.size(), 4);
    chk("incr_a0", 32'(qa[0]), 32'h100);
    chk("incr_a1", 32'(qa[1]), 32'h104);
    chk("incr_a2", 32'(qa[2]), 32'h108);
    chk("incr_a3", 32'(qa[3]), 32'h10C);
    chk("incr_d2", qd[2], 32'hA2);

    // WRAP 0x38 len=3 size=2
    clrq();
    aw(4'd1, 16'h0038, 8'd3, 3'd2, 2'b10);
    for (int i = 0; i < 4; i++) wbeat(32'h0, 4'hF, i == 3);
    bwait("wrap", 4'd1, 2'b00);
    chk("wrap_nwr", qa.size(), 4);
    chk("wrap_a0", 32'(qa[0]), 32'h38);
    chk("wrap_a1", 32'(qa[1]), 32'h3C);
    chk("wrap_a2", 32'(qa[2]), 32'h30);
    chk("wrap_a3", 32'(qa[3]), 32'h34);

    // FIXED 0x20 len=2 with walking strobes
    clrq();
    aw(4'd2, 16'h0020, 8'd2, 3'd2, 2'b00);
    wbeat(32'h11, 4'h1, 1'b0);
    wbeat(32'h22, 4'h2, 1'b0);
    wbeat(32'h33, 4'h4, 1'b1);
    bwait("fixed", 4'd2, 2'b00);
    chk("fixed_nwr", qa.size(), 3);
    chk("fixed_a2", 32'(qa[2]), 32'h20);
    chk("fixed_s0", 32'(qs[0]), 32'h1);
    chk("fixed_s1", 32'(qs[1]), 32'h2);
    chk("fixed_s2", 32'(qs[2]), 32'h4);

    // INCR unaligned start: only first beat unaligned
    clrq();
    aw(4'd3, 16'h0102, 8'd1, 3'd2, 2'b01);
    wbeat(32'h1, 4'hC, 1'b0);
    wbeat(32'h2, 4'hF, 1'b1);
    bwait("unal", 4'd3, 2'b00);
    chk("unal_a0", 32'(qa[0]), 32'h102);
    chk("unal_a1", 32'(qa[1]), 32'h104);

    // oversize beat: beats accepted, no writes, SLVERR
    clrq();
    aw(4'd6, 16'h0000, 8'd1, 3'd3, 2'b01);
    wbeat(32'h1, 4'hF, 1'b0);
    wbeat(32'h2, 4'hF, 1'b1);
    bwait("size", 4'd6, 2'b10);
    chk("size_nwr", qa.size(), 0);

    // WRAP with illegal len=2: no writes, SLVERR
    clrq();
    aw(4'd7, 16'h0000, 8'd2, 3'd2, 2'b10);
    for (int i = 0; i < 3; i++) wbeat(32'h0, 4'hF, i == 2);
    bwait("wraplen", 4'd7, 2'b10);
    chk("wraplen_nwr", qa.size(), 0);

    // early wlast on beat 2 of len=3: writes still done, SLVERR
    clrq();
    aw(4'd8, 16'h0200, 8'd3, 3'd2, 2'b01);
    for (int i = 0; i < 4; i++) wbeat(32'h0, 4'hF, i == 1);
    bwait("wlast", 4'd8, 2'b10);
    chk("wlast_nwr", qa.size(), 4);

    // reserved burst type acts as INCR with SLVERR
    clrq();
    aw(4'd9, 16'h0300, 8'd1, 3'd2, 2'b11);
    wbeat(32'h0, 4'hF, 1'b0);
    wbeat(32'h0, 4'hF, 1'b1);
    bwait("rsvd", 4'd9, 2'b10);
    chk("rsvd_a1", 32'(qa[1]), 32'h304);

    // bready held low for 10 cycles: B stable, no new AW
    clrq();
    aw(4'hA, 16'h0040, 8'd0, 3'd2, 2'b01);
    wbeat(32'h5, 4'hF, 1'b1);
    for (int i = 0; i < 10; i++) begin
      chk("hold_bvalid", 32'(bvalid), 1);
      chk("hold_bid", 32'(bid), 32'hA);
      chk("hold_bresp", 32'(bresp), 0);
      chk("hold_awready", 32'(awready), 0);
      @(negedge aclk);
    end
    bwait("hold", 4'hA, 2'b00);

    // reset in the middle of a len=7 burst
    clrq();
    aw(4'hB, 16'h0400, 8'd7, 3'd2, 2'b01);
    wbeat(32'h1, 4'hF, 1'b0);
    wbeat(32'h2, 4'hF, 1'b0);
    areset = 1'b1;
    #1;
    chk("mrst_wready", 32'(wready), 0);
    chk("mrst_awready", 32'(awready), 0);
    chk("mrst_mem_we", 32'(mem_we), 0);
    chk("mrst_mem_addr", 32'(mem_addr), 0);
    chk("mrst_bvalid", 32'(bvalid), 0);
    @(negedge aclk);
    areset = 1'b0;
    repeat (4) @(negedge aclk);
    chk("mrst_no_b", 32'(bvalid), 0);
    clrq();
    aw(4'hC, 16'h0500, 8'd1, 3'd2, 2'b01);
    wbeat(32'h7, 4'hF, 1'b0);
    wbeat(32'h8, 4'hF, 1'b1);
    bwait("after_rst", 4'hC, 2'b00);
    chk("after_rst_nwr", qa.size(), 2);
    chk("after_rst_a0", 32'(qa[0]), 32'h500);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
